// File: rtl/dm_pkg.sv
// Shared types and helpers for the wait-state data memory.
// Size codes, FSM states, captured-request bundle, lane helpers.
package dm_pkg;

  localparam int WS_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic aligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    unique case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Big-endian lanes: be[3] is bits [31:24] (offset 0).
  function automatic logic [3:0] lane_be(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (size)
      SZ_BYTE: be = 4'b1000 >> off;
      SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data onto every lane it may hit.
  function automatic logic [31:0] lane_rep(
    input logic [31:0] d,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = d;
    unique case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_ram.sv
// Word storage with per-byte write enables.
// Read port is registered and only updates when re is high.
module dm_lane_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane writes; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read, held between read enables.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dm_waitstate.sv
// Byte/half/word data memory with req/ready handshake and wait states.
// Word is fetched at acceptance so the access edge only extends it.
module dm_waitstate
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              misalign
);

  localparam logic [WS_W-1:0] WS_INIT = WS_W'(WAIT_STATES);

  state_t            st_q, st_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  acc_t              acc_q;
  logic [ADDR_W-1:0] wa_q;
  logic              ok, take, fire;
  logic              rdy_d, mis_d;
  logic [3:0]        be;
  logic [31:0]       ram_q;

  assign ok = aligned(size, addr[1:0]);
  assign be = (fire && acc_q.we)
            ? lane_be(acc_q.size, acc_q.off)
            : 4'b0000;

  function automatic logic [31:0] extend(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [31:0] sh, r;
    sh = 32'h0;
    r  = w;
    unique case (sz)
      SZ_BYTE: begin
        sh = w >> {~off, 3'b000};
        r  = uns ? {24'h0, sh[7:0]}
                 : {{24{sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        sh = w >> {~off[1], 4'b0000};
        r  = uns ? {16'h0, sh[15:0]}
                 : {{16{sh[15]}}, sh[15:0]};
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Next state, wait count and handshake pulses.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    rdy_d = 1'b0;
    mis_d = 1'b0;
    take  = 1'b0;
    fire  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (req) begin
          if (ok) begin
            take  = 1'b1;
            cnt_d = WS_INIT;
            st_d  = BUSY;
          end else begin
            st_d = ERR;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          fire  = 1'b1;
          rdy_d = 1'b1;
          st_d  = IDLE;
        end
      end
      ERR: begin
        rdy_d = 1'b1;
        mis_d = 1'b1;
        st_d  = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // State, counter and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      ready    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      ready    <= rdy_d;
      misalign <= mis_d;
    end
  end

  // Capture the request so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      wa_q  <= '0;
    end else if (take) begin
      acc_q.we    <= we;
      acc_q.size  <= size;
      acc_q.uns   <= unsigned_ld;
      acc_q.off   <= addr[1:0];
      acc_q.wdata <= lane_rep(wdata, size);
      wa_q        <= addr[ADDR_W+1:2];
    end
  end

  // Load result, held until the next load completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (fire && !acc_q.we) begin
      rdata <= extend(ram_q, acc_q.size,
                      acc_q.off, acc_q.uns);
    end
  end

  dm_lane_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .re   (take),
    .raddr(addr[ADDR_W+1:2]),
    .rdata(ram_q),
    .be   (be),
    .waddr(wa_q),
    .wdata(acc_q.wdata)
  );

endmodule

// File: doc/dm_waitstate.md
Name: dm_waitstate

Overview:
- Parametrised successor to the single-cycle word data memory in the MIPS datapath.
- Adds byte/halfword/word access with byte-lane writes, and sign/zero-extended loads.
- Uses a req/ready handshake with a configurable number of wait states, and flags misaligned accesses.
- Sits between the datapath's load/store unit and storage, so slow-memory timing can be modelled.

Parameters:
- ADDR_W, 10, word-index bits; depth = 2**ADDR_W words of 32 bits.
- WAIT_STATES, 0, extra busy cycles inserted before each access; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- unsigned_ld  input  1  1 = zero-extend loads, 0 = sign-extend.
- addr  input  ADDR_W+2  byte address; low 2 bits select the lane.
- wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ready  output  1  one-cycle pulse: the access (or its error) is complete.
- rdata  output  32  load result, valid while ready=1 for a load; holds until the next load completes.
- misalign  output  1  one-cycle pulse coincident with ready when the request was rejected.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, ready=0, misalign=0, rdata=0, wait counter=0. Memory contents are not reset (undefined after power-up).
- Byte lanes are big-endian:
  - byte offset 0 -> bits [31:24], offset 3 -> bits [7:0];
  - half at offset 0 -> [31:16], half at offset 2 -> [15:0].
- Alignment rules:
  - half requires addr[0]=0;
  - word requires addr[1:0]=00;
  - size=11 is always an error.
- States: IDLE, BUSY, ERR.
- IDLE with req=1 and a legal, aligned request:
  - latch addr, size, we, unsigned_ld and wdata;
  - load cnt=WAIT_STATES;
  - go to BUSY.
- IDLE with req=1 and an illegal request: go to ERR. No memory access is made.
- IDLE with req=0: stay in IDLE.
- BUSY, cnt != 0: decrement cnt.
- BUSY, cnt == 0, at that edge:
  - store: write only the selected byte lanes of the addressed word; other lanes are unchanged.
  - load: read the word, extract the lane, extend to 32 bits, register into rdata.
  - set ready=1 for the next cycle and return to IDLE.
- ERR: at the next edge set ready=1 and misalign=1 for one cycle and return to IDLE. rdata is unchanged.
- Latency: with the request accepted at edge E, ready is high during the cycle after edge E+1+WAIT_STATES. At WAIT_STATES=0, ready is high in the cycle following the cycle after acceptance.
- req is ignored while in BUSY or ERR; no queueing. A new req may be accepted in the same cycle ready is high, because the block is in IDLE then.
- Back-to-back throughput: one access per WAIT_STATES+2 cycles.
- A store completes with ready=1 and rdata unchanged.
- Reset mid-BUSY abandons the access: a store whose access edge has not occurred does not modify memory.
- Address wrap: none needed; addr covers exactly the memory depth.
- Inputs other than req are captured at acceptance; changes to them during BUSY have no effect.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - state enum {IDLE,BUSY,ERR};
  - the WAIT_STATES width constant (4 bits).
- One sub-module, dm_lane_ram: 2**ADDR_W x 32 storage with a 4-bit byte-write-enable and synchronous read.
- The lane-select/extend logic and the FSM stay in dm_waitstate.

Test Plan:
- WAIT_STATES=0; store word 0x12345678 @0x010, then load word @0x010 -> ready exactly 1 cycle after acceptance each time; rdata=0x12345678; misalign=0.
- After the above, store byte 0xAB @0x011, then load word @0x010 -> rdata=0x12AB5678. Load byte signed @0x011 -> 0xFFFFFFAB. Load byte unsigned -> 0x000000AB.
- Load half signed @0x012 from word 0x12AB8678 -> 0xFFFF8678. Store half 0xBEEF @0x012 then load word -> 0x12ABBEEF.
- Load word @0x012 -> ready+misalign pulse 1 cycle after acceptance; memory and rdata unchanged. Same result for size=11 and for half @0x013.
- WAIT_STATES=3 -> ready exactly 4 cycles after acceptance. req toggled during BUSY is ignored. A back-to-back req issued in the ready cycle is accepted.
- WAIT_STATES=3; store 0xFFFFFFFF @0x020 with rst asserted 2 cycles after acceptance -> all outputs 0 immediately; a later load of 0x020 returns the pre-store value.
